// File: rtl/bitsel_pkg.sv
// Shared types and constants for the bitsel configuration sequencer.
// The RA/RD states exist only when BITSEL_CFG_READBACK_EN is defined.
package bitsel_pkg;

    localparam int RESP_W   = 2;
    localparam int MAX_REGS = 16;
    localparam int IDX_W    = 4;

    localparam logic [RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
`ifdef BITSEL_CFG_READBACK_EN
        ST_RA,
        ST_RD,
`endif
        ST_NXT
    } state_e;

    // Byte offset of register idx inside the bank.
    function automatic logic [IDX_W+1:0] reg_offset(input logic [IDX_W-1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/bitsel_cfg_sequencer_if.sv
// AXI4-Lite bus between the configuration sequencer (master) and the bitsel slave.
interface bitsel_cfg_sequencer_if
    import bitsel_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;

    logic [RESP_W-1:0] bresp;
    logic              bvalid;
    logic              bready;

    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [31:0]       rdata;
    logic [RESP_W-1:0] rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_wr_beat.sv
// Single AXI4-Lite write transaction (AW + W + B) launched by a one-cycle req.
// aw_w_done flags the cycle the last of AW/W handshakes; ack flags the B handshake.
module axil_wr_beat
    import bitsel_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              aw_w_done,
    output logic              ack,
    output logic [RESP_W-1:0] resp,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic [RESP_W-1:0] bresp,
    input  logic              bvalid,
    output logic              bready
);

    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    // Both channels finish this cycle: each is either already done or handshaking now.
    assign aw_w_done = (awvalid_q | wvalid_q)
                     & (!awvalid_q | awready)
                     & (!wvalid_q  | wready);
    assign ack  = bready_q & bvalid;
    assign resp = bresp;

    always_comb begin
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        if (req) begin
            awaddr_d  = req_addr;
            wdata_d   = req_data;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end else begin
            if (awvalid_q && awready) begin
                awvalid_d = 1'b0;
            end
            if (wvalid_q && wready) begin
                wvalid_d = 1'b0;
            end
            if (aw_w_done) begin
                bready_d = 1'b1;
            end
            if (bready_q && bvalid) begin
                bready_d = 1'b0;
            end
        end
    end

    assign awaddr  = awaddr_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: rtl/bitsel_cfg_sequencer.sv
// AXI4-Lite master that writes NUM_REGS config words to the bitsel register bank on start.
// Define BITSEL_CFG_READBACK_EN to read back and verify every register after its write.
module bitsel_cfg_sequencer
    import bitsel_pkg::*;
#(
    parameter int                NUM_REGS  = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DATA_W    = 32
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       start,
    input  logic [NUM_REGS*DATA_W-1:0] cfg_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [IDX_W-1:0]           err_idx,
    bitsel_cfg_sequencer_if.master     m_axi
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] cfg_words [MAX_REGS];

    // Unused slots read as zero so idx can address the array at full width.
    generate
        for (genvar gi = 0; gi < MAX_REGS; gi++) begin : g_cfg
            if (gi < NUM_REGS) begin : g_used
                assign cfg_words[gi] = cfg_data[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign cfg_words[gi] = '0;
            end
        end
    endgenerate

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shadow_q [MAX_REGS];
    logic [DATA_W-1:0] shadow_d [MAX_REGS];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  err_idx_q, err_idx_d;
    logic              final_q, final_d;

    logic              wr_req;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [ADDR_W-1:0] cur_addr;
    logic              wr_aw_w_done;
    logic              wr_ack;
    logic [RESP_W-1:0] wr_resp;

    logic [ADDR_W-1:0] wr_awaddr;
    logic              wr_awvalid;
    logic [31:0]       wr_wdata;
    logic              wr_wvalid;
    logic              wr_bready;

`ifdef BITSEL_CFG_READBACK_EN
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
`endif

    assign cur_addr = BASE_ADDR + ADDR_W'(reg_offset(idx_q));

    axil_wr_beat #(
        .ADDR_W (ADDR_W)
    ) u_wr_beat (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req       (wr_req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .aw_w_done (wr_aw_w_done),
        .ack       (wr_ack),
        .resp      (wr_resp),
        .awaddr    (wr_awaddr),
        .awvalid   (wr_awvalid),
        .awready   (m_axi.awready),
        .wdata     (wr_wdata),
        .wvalid    (wr_wvalid),
        .wready    (m_axi.wready),
        .bresp     (m_axi.bresp),
        .bvalid    (m_axi.bvalid),
        .bready    (wr_bready)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            final_q   <= 1'b0;
            for (int i = 0; i < MAX_REGS; i++) begin
                shadow_q[i] <= '0;
            end
`ifdef BITSEL_CFG_READBACK_EN
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            final_q   <= final_d;
            shadow_q  <= shadow_d;
`ifdef BITSEL_CFG_READBACK_EN
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        final_d   = final_q;
        wr_req    = 1'b0;
`ifdef BITSEL_CFG_READBACK_EN
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // done_q is high only in the first IDLE cycle; a start there is dropped.
                if (start && !done_q) begin
                    shadow_d = cfg_words;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    final_d  = 1'b0;
                    wr_req   = 1'b1;
                    state_d  = ST_WR;
                end
            end
            ST_WR: begin
                if (wr_aw_w_done) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (wr_ack) begin
                    if (wr_resp != AXI_RESP_OKAY) begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        final_d   = 1'b1;
                        state_d   = ST_NXT;
                    end else begin
`ifdef BITSEL_CFG_READBACK_EN
                        araddr_d  = cur_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RA;
`else
                        state_d   = ST_NXT;
`endif
                    end
                end
            end
`ifdef BITSEL_CFG_READBACK_EN
            ST_RA: begin
                if (arvalid_q && m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD;
                end
            end
            ST_RD: begin
                if (rready_q && m_axi.rvalid) begin
                    rready_d = 1'b0;
                    if (m_axi.rresp != AXI_RESP_OKAY || m_axi.rdata != shadow_q[idx_q]) begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        final_d   = 1'b1;
                    end
                    state_d = ST_NXT;
                end
            end
`endif
            ST_NXT: begin
                if (final_q || idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    wr_req  = 1'b1;
                    state_d = ST_WR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Launch address/data follow the index the FSM is moving to.
        req_addr = BASE_ADDR + ADDR_W'(reg_offset(idx_d));
        req_data = shadow_d[idx_d];
    end

    assign m_axi.awaddr  = wr_awaddr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = wr_awvalid;
    assign m_axi.wdata   = wr_wdata;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wr_wvalid;
    assign m_axi.bready  = wr_bready;
    assign m_axi.arprot  = 3'b000;

`ifdef BITSEL_CFG_READBACK_EN
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
`else
    logic unused_rd_ok;
    assign unused_rd_ok  = ^{m_axi.arready, m_axi.rdata, m_axi.rresp, m_axi.rvalid};
    assign m_axi.araddr  = '0;
    assign m_axi.arvalid = 1'b0;
    assign m_axi.rready  = 1'b0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_idx = err_idx_q;

endmodule

// File: tb/tb_bitsel_cfg_sequencer.sv
// Randomized bench for bitsel_cfg_sequencer: AXI4-Lite slave model with wait states,
// error injection, and an expected write list derived from the register map.
module tb_bitsel_cfg_sequencer;
    import bitsel_pkg::*;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h44A0_0000;
`ifdef BITSEL_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam logic [31:0] FIXED [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic            start = 1'b0;
    logic [N*32-1:0] cfg_data = '0;
    logic            busy, done, err;
    logic [3:0]      err_idx;

    bitsel_cfg_sequencer_if #(.ADDR_W(32)) axi ();

    bitsel_cfg_sequencer #(
        .NUM_REGS  (N),
        .ADDR_W    (32),
        .BASE_ADDR (BASE),
        .DATA_W    (32)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .start    (start),
        .cfg_data (cfg_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_idx  (err_idx),
        .m_axi    (axi.master)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- slave model ----------------
    int mode = 0;           // 0 zero-wait, 1 random waits, 2 AWREADY after 3 cycles
    int berr_idx = -1;      // register answered with SLVERR
    int rerr_idx = -1;      // register whose readback has bit 0 forced low
    int aw_cnt, w_cnt, b_cnt, aw_rnd, w_rnd, b_rnd;
    int aw_dly, w_dly, b_dly;
    logic aw_got, w_got, b_pend;
    logic [31:0] aw_addr_s, w_data_s, cur_a, cur_d;
    logic aw_hs, w_hs, both_now;
    logic [31:0] mem [16];
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t wlog [$];

    function automatic int reg_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    always_comb begin
        aw_dly = (mode == 0) ? 0 : (mode == 2) ? 3 : aw_rnd;
        w_dly  = (mode == 1) ? w_rnd : 0;
        b_dly  = (mode == 1) ? b_rnd : 0;
    end

    assign axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_dly);
    assign axi.wready  = axi.wvalid && !w_got && (w_cnt >= w_dly);
    assign axi.arready = axi.arvalid;
    assign aw_hs    = axi.awvalid & axi.awready;
    assign w_hs     = axi.wvalid & axi.wready;
    assign both_now = (aw_got | aw_hs) & (w_got | w_hs);
    assign cur_a    = aw_hs ? axi.awaddr : aw_addr_s;
    assign cur_d    = w_hs ? axi.wdata : w_data_s;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            aw_rnd <= 0; w_rnd <= 0; b_rnd <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
            aw_addr_s <= '0; w_data_s <= '0;
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_cnt <= 0; aw_got <= 1'b1; aw_addr_s <= axi.awaddr;
                aw_rnd <= int'($urandom_range(0, 3));
            end else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                w_cnt <= 0; w_got <= 1'b1; w_data_s <= axi.wdata;
                w_rnd <= int'($urandom_range(0, 3));
            end else if (axi.wvalid) w_cnt <= w_cnt + 1;
            if (both_now) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
                wlog.push_back('{cur_a, cur_d});
                if (reg_of(cur_a) == berr_idx) axi.bresp <= 2'b10;
                else begin
                    axi.bresp <= 2'b00;
                    if (reg_of(cur_a) >= 0 && reg_of(cur_a) < 16) mem[reg_of(cur_a)] <= cur_d;
                end
                if (b_dly == 0) axi.bvalid <= 1'b1;
            end else if (b_pend && !axi.bvalid) begin
                b_cnt <= b_cnt + 1;
                if (b_cnt + 1 >= b_dly) axi.bvalid <= 1'b1;
            end
            if (axi.bvalid && axi.bready) begin
                axi.bvalid <= 1'b0; b_pend <= 1'b0;
                b_rnd <= int'($urandom_range(0, 3));
            end
        end
    end

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= 2'b00;
        end else if (axi.arvalid && axi.arready) begin
            axi.rvalid <= 1'b1;
            axi.rresp  <= 2'b00;
            axi.rdata  <= mem[reg_of(axi.araddr) & 15] & ((reg_of(axi.araddr) == rerr_idx) ? ~32'h1 : 32'hFFFF_FFFF);
        end else if (axi.rvalid && axi.rready) begin
            axi.rvalid <= 1'b0;
        end
    end

    // ---------------- protocol monitor ----------------
    int viol = 0, aw_only = 0, ar_seen = 0;
    logic aw_pend_p = 1'b0, w_pend_p = 1'b0;
    logic [31:0] aw_a_p, w_d_p;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            aw_pend_p <= 1'b0; w_pend_p <= 1'b0;
        end else begin
            viol <= viol + int'(aw_pend_p && (!axi.awvalid || axi.awaddr !== aw_a_p))
                         + int'(w_pend_p && (!axi.wvalid || axi.wdata !== w_d_p));
            aw_pend_p <= axi.awvalid & !axi.awready;
            w_pend_p  <= axi.wvalid & !axi.wready;
            aw_a_p    <= axi.awaddr;
            w_d_p     <= axi.wdata;
            if (axi.awvalid && !axi.wvalid) aw_only <= aw_only + 1;
            if (axi.arvalid) ar_seen <= ar_seen + 1;
        end
    end

    // ---------------- one configuration sequence ----------------
    task automatic run_seq(input string name, input int m, input int berr, input int rerr, input bit fixed_cfg);
        logic [31:0] words [N];
        int fail, exp_n, cyc, stray, aw_only0, per;
        bit seen;
        mode = m; berr_idx = berr; rerr_idx = rerr;
        fail = -1;
        for (int i = 0; i < N; i++) words[i] = fixed_cfg ? FIXED[i] : $urandom;
        for (int i = N - 1; i >= 0; i--) begin
            if (i == berr || (RB && i == rerr)) fail = i;
        end
        exp_n = (fail >= 0) ? fail + 1 : N;
        wlog.delete();
        @(negedge ACLK);
        for (int i = 0; i < N; i++) cfg_data[32*i +: 32] = words[i];
        start = 1'b1;
        aw_only0 = aw_only;
        seen = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge ACLK);
            cyc = c;
            if (done) begin seen = 1'b1; break; end
            cfg_data = {$urandom, $urandom, $urandom, $urandom};
            start = (c == 2);
        end
        check({name, ":done_seen"}, 64'(seen), 64'd1);
        check({name, ":err"}, 64'(err), 64'(fail >= 0));
        if (fail >= 0) check({name, ":err_idx"}, 64'(err_idx), 64'(fail));
        check({name, ":nwrites"}, 64'(wlog.size()), 64'(exp_n));
        for (int i = 0; i < exp_n && i < wlog.size(); i++) begin
            check($sformatf("%s:addr%0d", name, i), 64'(wlog[i].addr), 64'(BASE + 32'(4 * i)));
            check($sformatf("%s:data%0d", name, i), 64'(wlog[i].data), 64'(words[i]));
            if (i != berr) check($sformatf("%s:mem%0d", name, i), 64'(mem[i]), 64'(words[i]));
        end
        if (fail < 0 && m != 1) begin
            per = ((m == 2) ? 6 : 3) + (RB ? 2 : 0);
            check({name, ":latency"}, 64'(cyc - 1), 64'(per * N));
        end
        if (m == 2) check({name, ":aw_only_cycles"}, 64'(aw_only - aw_only0), 64'(3 * exp_n));
        $display("run %s: mode=%0d writes=%0d err=%0b err_idx=%0d cycles=%0d",
                 name, m, wlog.size(), err, err_idx, cyc - 1);
        // start coincident with done must not launch a new sequence
        start = 1'b1;
        stray = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge ACLK);
            start = 1'b0;
            stray += int'(done) + int'(busy);
        end
        check({name, ":no_restart"}, 64'(stray), 64'd0);
    endtask

    task automatic reset_mid_seq();
        bit found;
        int stray;
        mode = 0; berr_idx = -1; rerr_idx = -1;
        wlog.delete();
        @(negedge ACLK);
        cfg_data = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        found = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge ACLK);
            start = 1'b0;
            if (wlog.size() == 1 && axi.awvalid) begin found = 1'b1; break; end
        end
        check("rst:reached_wr1", 64'(found), 64'd1);
        check("rst:awaddr_wr1", 64'(axi.awaddr), 64'(BASE + 32'd4));
        #2 ARESETN = 1'b0;
        #1;
        check("rst:awvalid", 64'(axi.awvalid), 64'd0);
        check("rst:wvalid", 64'(axi.wvalid), 64'd0);
        check("rst:busy", 64'(busy), 64'd0);
        stray = int'(done);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            stray += int'(done) + int'(busy);
        end
        check("rst:idle_after", 64'(stray), 64'd0);
        $display("run reset_mid: writes_before_reset=%0d", wlog.size());
    endtask

    initial begin
        repeat (3) @(negedge ACLK);
        check("reset:awvalid", 64'(axi.awvalid), 64'd0);
        check("reset:wvalid", 64'(axi.wvalid), 64'd0);
        check("reset:bready", 64'(axi.bready), 64'd0);
        check("reset:arvalid", 64'(axi.arvalid), 64'd0);
        check("reset:rready", 64'(axi.rready), 64'd0);
        check("reset:busy", 64'(busy), 64'd0);
        check("reset:done", 64'(done), 64'd0);
        check("reset:err", 64'(err), 64'd0);
        check("reset:err_idx", 64'(err_idx), 64'd0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        run_seq("basic", 0, -1, -1, 1'b1);
        run_seq("aw_wait3", 2, -1, -1, 1'b1);
        run_seq("bresp_err2", 0, 2, -1, 1'b0);
        run_seq("recover", 0, -1, -1, 1'b0);
`ifdef BITSEL_CFG_READBACK_EN
        run_seq("rb_err1", 0, -1, 1, 1'b1);
`endif
        reset_mid_seq();
        run_seq("after_reset", 0, -1, -1, 1'b0);
        for (int r = 0; r < 10; r++) begin
            run_seq($sformatf("rand%0d", r), 1, int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), 1'b0);
        end

        check("aw_w_stable", 64'(viol), 64'd0);
`ifndef BITSEL_CFG_READBACK_EN
        check("ar_idle", 64'(ar_seen), 64'd0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
